// File: rtl/prog_loader_if.sv
// Program loader bus: upstream byte stream, load control/status and the
// CPU-side instruction read port. clk/reset stay plain ports on the module.
interface prog_loader_if;
   logic       START;
   logic       IN_VALID;
   logic [7:0] IN_DATA;
   logic       IN_READY;
   logic [3:0] Address;
   logic [7:0] Order;
   logic       CPU_HOLD;
   logic       DONE;
   logic       ERR;

   // Testbench / upstream side.
   modport master (
      output START, IN_VALID, IN_DATA, Address,
      input  IN_READY, Order, CPU_HOLD, DONE, ERR
   );

   // Loader side.
   modport slave (
      input  START, IN_VALID, IN_DATA, Address,
      output IN_READY, Order, CPU_HOLD, DONE, ERR
   );
endinterface : prog_loader_if

// File: rtl/prog_loader.sv
// Program loader: streams 16 program bytes into a 16x8 instruction store
// while holding the CPU in reset, then releases it HOLD_CYCLES cycles after
// the last accepted byte and pulses DONE.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to add a trailing
// checksum byte (CHECK state) that is compared against the running sum of
// the 16 program bytes; a mismatch sets the sticky ERR flag.
module prog_loader #(
   parameter int unsigned HOLD_CYCLES = 2   // legal range 1..15
) (
   input  logic          CLK,
   input  logic          CLR,
   prog_loader_if.slave  bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
`endif

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  wptr_q;
   logic [3:0]  wptr_d;
   logic [3:0]  hold_cnt_q;
   logic [7:0]  mem_q [16];
   logic        in_ready_q;
   logic        cpu_hold_q;
   logic        done_q;
   logic        accept;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q;
   logic [7:0]  sum_d;
   logic        err_q;

   // Running modulo-256 sum of the accepted program bytes.
   assign sum_d   = sum_q + bus.IN_DATA;
   assign bus.ERR = err_q;
`else
   assign bus.ERR = 1'b0;
`endif

   // A byte moves only when the loader advertises ready and upstream is valid.
   assign accept = bus.IN_VALID & in_ready_q;
   // 4-bit pointer wraps naturally from 15 back to 0.
   assign wptr_d = wptr_q + 4'd1;

   // Instruction read is a plain array lookup: a write this cycle shows up next cycle.
   assign bus.Order    = mem_q[bus.Address];
   assign bus.IN_READY = in_ready_q;
   assign bus.CPU_HOLD = cpu_hold_q;
   assign bus.DONE     = done_q;

   // Load sequencer: state, pointer, counters, storage and registered outputs.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         hold_cnt_q <= '0;
         in_ready_q <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q      <= '0;
         err_q      <= 1'b0;
`endif
         // NOTE: the store is deliberately cleared on reset so a CPU released
         // after an aborted load never fetches stale code; this keeps it in flops.
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking everywhere here so every register sees the
         // pre-edge values regardless of statement order.
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.START) begin
                  state_q    <= LOAD;
                  wptr_q     <= '0;
                  in_ready_q <= 1'b1;
                  cpu_hold_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_q      <= '0;
                  err_q      <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (accept) begin
                  mem_q[wptr_q] <= bus.IN_DATA;
                  wptr_q        <= wptr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
                  sum_q         <= sum_d;
                  if (wptr_q == 4'hF) begin
                     state_q <= CHECK;
                  end
`else
                  if (wptr_q == 4'hF) begin
                     state_q    <= HOLD;
                     in_ready_q <= 1'b0;
                     hold_cnt_q <= '0;
                  end
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
               if (accept) begin
                  err_q      <= (bus.IN_DATA != sum_q);
                  state_q    <= HOLD;
                  in_ready_q <= 1'b0;
                  hold_cnt_q <= '0;
               end
            end
`endif
            HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q    <= IDLE;
                  cpu_hold_q <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 4'd1;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
               cpu_hold_q <= 1'b0;
            end
         endcase
      end
   end

endmodule : prog_loader
